dxl_bus_scheduler: RTL and testbench
====================================

DXL_BUS_SCHEDULER -- requirements
Module: dxl_bus_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester ports (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: maximum cycles from eng_start to eng_done before abort.
REQ-003 Parameter GAP_CYCLES, default 100: idle bus cycles enforced between transactions.
REQ-004 clock  input  1  system clock; reset  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NUM_REQ  per-requester transaction request, level, held until matching done pulse.
REQ-006 req_id  input  8*NUM_REQ  servo ID, slice k for requester k.
REQ-007 req_instr  input  8*NUM_REQ  Dynamixel instruction byte (PING/READ/WRITE/...).
REQ-008 req_addr  input  16*NUM_REQ  control-table address.
REQ-009 req_value  input  16*NUM_REQ  write data or read length.
REQ-010 req_reply  input  NUM_REQ  1 = status packet expected.
REQ-011 done  output  NUM_REQ  one-cycle completion pulse, bit k for requester k.
REQ-012 status  output  2  result valid with done: 00 ok, 01 CRC/header error, 10 timeout.
REQ-013 rd_value  output  16  returned parameter value, valid with done.
REQ-014 eng_start  output  1  one-cycle start pulse to packet engine.
REQ-015 eng_id/eng_instr/eng_addr/eng_value/eng_reply  output  8/8/16/16/1  registered transaction fields, stable from eng_start until eng_done or eng_abort.
REQ-016 eng_abort  output  1  one-cycle pulse, forces engine to idle and releases bus.
REQ-017 eng_busy  input  1  engine active.
REQ-018 eng_done  input  1  one-cycle pulse, transaction finished.
REQ-019 eng_err  input  1  CRC/header error, valid with eng_done.
REQ-020 eng_rx_value  input  16  received parameter, valid with eng_done.

Function
REQ-021 FSM states IDLE, ARB, ISSUE, WAIT, GAP; encoding free.
REQ-022 IDLE: when any req bit is high and eng_busy is low, go to ARB next cycle.
REQ-023 ARB: round-robin select, first asserted req at or after pointer ptr, wrapping from NUM_REQ-1 to 0; latch index in grant_idx; copy fields to eng_* regs; go to ISSUE.
REQ-024 ISSUE: assert eng_start for exactly one cycle; clear timeout counter; go to WAIT.
REQ-025 Latency: req rising in IDLE with engine idle -> eng_start exactly 2 cycles later.
REQ-026 WAIT: counter increments each cycle; on eng_done, pulse done[grant_idx] next cycle with status = {0,eng_err}, rd_value = eng_rx_value if eng_reply else 0; go to GAP.
REQ-027 WAIT timeout: counter reaching TIMEOUT_CYCLES-1 without eng_done -> eng_abort one cycle, done[grant_idx] with status 10, rd_value 0; go to GAP.
REQ-028 eng_done in the same cycle as timeout expiry: eng_done wins, status from eng_err, no eng_abort.
REQ-029 Pointer update: on leaving WAIT, ptr = grant_idx+1 modulo NUM_REQ.
REQ-030 GAP: count GAP_CYCLES cycles, then IDLE; req changes during GAP are ignored until IDLE.
REQ-031 Requester dropping req while granted: transaction still completes; done still pulses.
REQ-032 Only one done bit high per cycle; done never pulses without a preceding eng_start for that index.
REQ-033 eng_start never issued while eng_busy is high.
REQ-034 Counter width ceil(log2(max(TIMEOUT_CYCLES, GAP_CYCLES))) bits, no wrap before expiry.

Reset
REQ-035 Reset asserted: state IDLE, ptr 0, grant_idx 0, counter 0, done 0, status 00, rd_value 0, eng_start 0, eng_abort 0, all eng_* fields 0, asynchronously.
REQ-036 Reset mid-transaction: no done pulse, no eng_abort; after release, first eng_start only on fresh arbitration.

Verification
REQ-037 req=0001, id 1, WRITE addr 30 value 512, reply 0; engine done after 200 cycles -> eng_start at cycle 2, done=0001, status 00, rd_value 0.
REQ-038 req=1111 held, engine done each time -> grant order 0,1,2,3,0, with at least GAP_CYCLES idle between eng_start pulses.
REQ-039 READ addr 37 reply 1, engine returns 0x01FF with eng_err 0 -> rd_value 0x01FF, status 00; repeat with eng_err 1 -> status 01.
REQ-040 Engine never returns eng_done -> eng_abort and done with status 10 exactly TIMEOUT_CYCLES cycles after eng_start.
REQ-041 eng_done on timeout-expiry cycle -> status 00, no eng_abort.
REQ-042 Reset asserted in WAIT -> all outputs 0 immediately, no done; req=0100 after release -> grant index 2.

Source files
------------

// File: rtl/dxl_bus_scheduler.sv
// Round-robin scheduler that shares one Dynamixel packet engine among NUM_REQ requesters,
// with a per-transaction timeout and an enforced idle gap between bus transactions.
//
// state | meaning
// IDLE  | bus free, waiting for a request while the engine is idle
// ARB   | round-robin pick, latch grant and transaction fields
// ISSUE | eng_start pulse is on the wire, timeout count begins
// WAIT  | engine running; finish on eng_done or abort on timeout
// GAP   | enforced bus idle time before the next arbitration
module dxl_bus_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int GAP_CYCLES     = 100
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [8*NUM_REQ-1:0]    req_id,
  input  logic [8*NUM_REQ-1:0]    req_instr,
  input  logic [16*NUM_REQ-1:0]   req_addr,
  input  logic [16*NUM_REQ-1:0]   req_value,
  input  logic [NUM_REQ-1:0]      req_reply,
  output logic [NUM_REQ-1:0]      done,
  output logic [1:0]              status,
  output logic [15:0]             rd_value,
  output logic                    eng_start,
  output logic [7:0]              eng_id,
  output logic [7:0]              eng_instr,
  output logic [15:0]             eng_addr,
  output logic [15:0]             eng_value,
  output logic                    eng_reply,
  output logic                    eng_abort,
  input  logic                    eng_busy,
  input  logic                    eng_done,
  input  logic                    eng_err,
  input  logic [15:0]             eng_rx_value
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(NUM_REQ);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, GAP} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant_idx;
  logic [CW-1:0]   cnt;
  logic            pick_ok;
  logic [IW-1:0]   pick_idx;
  logic [IW:0]     pick_j;

  // Scan from the highest offset down so the nearest request at/after ptr wins.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    pick_j   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pick_j = {1'b0, ptr} + (IW+1)'(i);
      if (pick_j >= (IW+1)'(NUM_REQ)) pick_j = pick_j - (IW+1)'(NUM_REQ);
      if (req[pick_j[IW-1:0]]) begin
        pick_ok  = 1'b1;
        pick_idx = pick_j[IW-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      cnt       <= '0;
      done      <= '0;
      status    <= 2'b00;
      rd_value  <= '0;
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      eng_id    <= '0;
      eng_instr <= '0;
      eng_addr  <= '0;
      eng_value <= '0;
      eng_reply <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      done      <= '0;
      case (state)
        IDLE: begin
          if (|req && !eng_busy) state <= ARB;
        end
        ARB: begin
          // Request may have vanished or the engine gone busy since IDLE; retry from IDLE.
          if (pick_ok && !eng_busy) begin
            grant_idx <= pick_idx;
            eng_id    <= req_id[8*pick_idx +: 8];
            eng_instr <= req_instr[8*pick_idx +: 8];
            eng_addr  <= req_addr[16*pick_idx +: 16];
            eng_value <= req_value[16*pick_idx +: 16];
            eng_reply <= req_reply[pick_idx];
            eng_start <= 1'b1;
            cnt       <= '0;
            state     <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          cnt   <= cnt + 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (eng_done || cnt == TO_LAST) begin
            done   <= NUM_REQ'(1) << grant_idx;
            ptr    <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            cnt    <= '0;
            state  <= GAP;
            if (eng_done) begin
              status   <= {1'b0, eng_err};
              rd_value <= eng_reply ? eng_rx_value : 16'h0000;
            end else begin
              eng_abort <= 1'b1;
              status    <= 2'b10;
              rd_value  <= 16'h0000;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) state <= IDLE;
          else                 cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dxl_bus_scheduler.sv
// Scoreboard bench for dxl_bus_scheduler: stimulus drives requesters and a model engine,
// a monitor checks every done pulse against expectations queued from a round-robin reference.
module tb_dxl_bus_scheduler;
  localparam int N = 4;
  localparam int T = 300;
  localparam int G = 10;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [8*N-1:0]    req_id, req_instr;
  logic [16*N-1:0]   req_addr, req_value;
  logic [N-1:0]      req_reply;
  logic [N-1:0]      done;
  logic [1:0]        status;
  logic [15:0]       rd_value;
  logic              eng_start, eng_reply, eng_abort;
  logic [7:0]        eng_id, eng_instr;
  logic [15:0]       eng_addr, eng_value;
  logic              eng_busy, eng_done, eng_err;
  logic [15:0]       eng_rx_value;

  logic [7:0]  f_id[N], f_instr[N];
  logic [15:0] f_addr[N], f_val[N];
  logic        f_reply[N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_id[8*k +: 8]      = f_id[k];
      req_instr[8*k +: 8]   = f_instr[k];
      req_addr[16*k +: 16]  = f_addr[k];
      req_value[16*k +: 16] = f_val[k];
      req_reply[k]          = f_reply[k];
    end
  end

  dxl_bus_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .GAP_CYCLES(G)) dut (
    .clock(clock), .reset(reset), .req(req), .req_id(req_id), .req_instr(req_instr),
    .req_addr(req_addr), .req_value(req_value), .req_reply(req_reply), .done(done),
    .status(status), .rd_value(rd_value), .eng_start(eng_start), .eng_id(eng_id),
    .eng_instr(eng_instr), .eng_addr(eng_addr), .eng_value(eng_value), .eng_reply(eng_reply),
    .eng_abort(eng_abort), .eng_busy(eng_busy), .eng_done(eng_done), .eng_err(eng_err),
    .eng_rx_value(eng_rx_value)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   idx;
    int   st;
    int   rd;
    int   at;
    bit   abort;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int  exp_ptr = 0;
  int  prev_start;
  bit  have_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Round-robin rule: first asserted request at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic rand_fields();
    for (int k = 0; k < N; k++) begin
      f_id[k]    = 8'(($urandom_range(0, 63) << 2) | k);
      f_instr[k] = 8'($urandom);
      f_addr[k]  = 16'($urandom);
      f_val[k]   = 16'($urandom);
      f_reply[k] = 1'($urandom_range(0, 1));
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (done != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("done_bits", 32'(done), 32'(1 << mon_e.idx));
          chk("status", 32'(status), 32'(mon_e.st));
          chk("rd_value", 32'(rd_value), 32'(mon_e.rd));
          chk("done_cycle", 32'(cyc), 32'(mon_e.at));
          chk("abort_with_done", 32'(eng_abort), 32'(mon_e.abort));
        end
      end else if (eng_abort) begin
        chk("abort_without_done", 32'(eng_abort), 32'd0);
      end
    end
  end

  // Returns the observed eng_start cycle, or -1 if none within the bound.
  task automatic wait_start(output int s);
    s = -1;
    for (int k = 0; k < G + T + 50; k++) begin
      @(negedge clock);
      if (eng_start) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) bound_fail("eng_start_wait");
  endtask

  task automatic run_txn(input logic [N-1:0] rv, input bit fresh, input int lat,
                         input bit err, input logic [15:0] rx, input bit drop);
    int g, r, s;
    @(posedge clock); #1;
    if (fresh) begin
      req = '0;
      repeat (G + 3) @(posedge clock);
      #1;
    end
    r   = cyc;
    req = rv;
    g   = rr_pick(rv, exp_ptr);
    wait_start(s);
    if (s < 0) return;
    if (fresh) chk("start_latency", 32'(s - r), 32'd2);
    chk("grant_id", 32'(eng_id), 32'(f_id[g]));
    chk("grant_instr", 32'(eng_instr), 32'(f_instr[g]));
    chk("grant_addr", 32'(eng_addr), 32'(f_addr[g]));
    chk("grant_value", 32'(eng_value), 32'(f_val[g]));
    chk("grant_reply", 32'(eng_reply), 32'(f_reply[g]));
    if (have_prev) chk("start_spacing_over_gap", 32'((s - prev_start) > G), 32'd1);
    prev_start = s;
    have_prev  = 1'b1;
    exp_ptr    = (g + 1) % N;
    @(posedge clock); #1;
    eng_busy = 1'b1;
    if (drop) req[g] = 1'b0;
    if (lat < 0) begin
      sb.push_back('{idx: g, st: 2, rd: 0, at: s + T, abort: 1'b1});
    end else begin
      for (int k = 1; k < lat; k++) begin
        @(posedge clock); #1;
      end
      eng_err      = err;
      eng_rx_value = rx;
      eng_done     = 1'b1;
      sb.push_back('{idx: g, st: (err ? 1 : 0), rd: (f_reply[g] ? int'(rx) : 0),
                     at: s + lat + 1, abort: 1'b0});
      @(posedge clock); #1;
      eng_done = 1'b0;
      eng_err  = 1'b0;
      eng_busy = 1'b0;
    end
    for (int k = 0; k < T + 50 && sb.size() != 0; k++) @(negedge clock);
    if (sb.size() != 0) begin
      bound_fail("done_wait");
      sb.delete();
    end
    eng_busy = 1'b0;
  endtask

  initial begin
    int s;
    reset = 1'b1;
    req = '0;
    eng_busy = 1'b0; eng_done = 1'b0; eng_err = 1'b0; eng_rx_value = '0;
    rand_fields();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_rd_value", 32'(rd_value), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_eng_fields", {eng_id, eng_instr, eng_addr[7:0], eng_value[6:0], eng_reply}, 32'd0);
    reset = 1'b0;

    // All requesters held: grants rotate 0,1,2,3,0.
    rand_fields();
    run_txn(4'b1111, 1'b1, 30, 1'b0, 16'h0A0A, 1'b0);
    for (int k = 0; k < 4; k++) run_txn(4'b1111, 1'b0, 5 + 7 * k, k[0], 16'(k * 3 + 1), 1'b0);

    // Single WRITE, reply not expected, engine takes 200 cycles.
    rand_fields();
    f_id[0] = 8'd1; f_instr[0] = 8'h03; f_addr[0] = 16'd30; f_val[0] = 16'd512; f_reply[0] = 1'b0;
    run_txn(4'b0001, 1'b1, 200, 1'b0, 16'hBEEF, 1'b0);

    // READ with reply, clean then with CRC error.
    f_instr[1] = 8'h02; f_addr[1] = 16'd37; f_val[1] = 16'd2; f_reply[1] = 1'b1;
    run_txn(4'b0010, 1'b1, 25, 1'b0, 16'h01FF, 1'b0);
    run_txn(4'b0010, 1'b1, 25, 1'b1, 16'h01FF, 1'b0);

    // Timeout, done exactly at expiry, done one cycle before expiry.
    rand_fields();
    run_txn(4'b1000, 1'b1, -1, 1'b0, 16'h0, 1'b0);
    f_reply[2] = 1'b1;
    run_txn(4'b0100, 1'b1, T - 1, 1'b0, 16'h1357, 1'b0);
    run_txn(4'b0100, 1'b1, T - 2, 1'b1, 16'h2468, 1'b0);

    // Randomized traffic, including requests dropped while granted.
    for (int n = 0; n < 14; n++) begin
      logic [N-1:0] rv;
      rand_fields();
      rv = N'($urandom_range(1, (1 << N) - 1));
      run_txn(rv, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 80)),
              1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of WAIT: outputs clear at once, no done, fresh arbitration after.
    rand_fields();
    @(posedge clock); #1;
    req = '0;
    repeat (G + 3) @(posedge clock);
    #1;
    req = 4'b0011;
    wait_start(s);
    @(posedge clock); #1;
    eng_busy = 1'b1;
    repeat (20) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_abort", 32'(eng_abort), 32'd0);
    chk("midrst_start", 32'(eng_start), 32'd0);
    chk("midrst_fields", {eng_id, eng_instr, eng_addr[7:0], eng_value[6:0], eng_reply}, 32'd0);
    chk("midrst_result", {status, rd_value}, 32'd0);
    sb.delete();
    exp_ptr   = 0;
    have_prev = 1'b0;
    eng_busy  = 1'b0;
    req       = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    run_txn(4'b0100, 1'b1, 40, 1'b0, 16'h0042, 1'b0);
    run_txn(4'b1001, 1'b1, 12, 1'b0, 16'h0077, 1'b0);

    repeat (5) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
